imem_loader: RTL and testbench

//   Loadable 8-bit instruction memory that sits directly upstream of the CPU core.
//   It accepts a program as a byte stream over a valid/ready load port, then serves

---
 rtl/imem_loader.sv | 137 +++++++++++++
 tb/tb_imem_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: loadable 8-bit instruction memory in front of the CPU core.
// A program arrives as a valid/ready byte stream. The memory then serves
// registered fetch data for the CPU pc. The CPU is held in reset except in RUN.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no program loaded since reset; CPU held in reset
// S_LOAD | accepting program bytes; CPU held in reset
// S_RUN  | program loaded; serving fetches, CPU released from reset
module imem_loader #(
  parameter int         DEPTH     = 256,
  parameter logic [7:0] HOLD_INSN = 8'hC3
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic [7:0] address,
  output logic [7:0] instruction,
  output logic       cpu_reset,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  output logic       running,
  output logic [8:0] prog_len,
  output logic       overflow
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [8:0]      r_wptr;
  logic [8:0]      w_wptr_nxt;
  logic [8:0]      r_prog_len;
  logic [8:0]      w_prog_len_nxt;
  logic            r_overflow;
  logic            w_overflow_nxt;
  logic            w_we;
  logic            r_load_ready;
  logic            r_cpu_reset;
  logic            r_running;
  logic [7:0]      r_instruction;
  logic [7:0]      r_mem [DEPTH];
  logic            w_fetch_hit;
  logic [AW-1:0]   w_raddr;

  // Fetches beyond the loaded program never touch the array.
  assign w_fetch_hit = ({1'b0, address} < r_prog_len);
  assign w_raddr     = w_fetch_hit ? address[AW-1:0] : '0;

  // Next-state, write-pointer and status decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_wptr_nxt     = r_wptr;
    w_prog_len_nxt = r_prog_len;
    w_overflow_nxt = r_overflow;
    w_we           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load_start) begin
          w_state_nxt    = S_LOAD;
          w_wptr_nxt     = '0;
          w_prog_len_nxt = '0;
          w_overflow_nxt = 1'b0;
        end
      end
      S_LOAD: begin
        if (load_start) begin
          // restart wins over a same-cycle transfer, which is dropped
          w_wptr_nxt     = '0;
          w_prog_len_nxt = '0;
          w_overflow_nxt = 1'b0;
        end else if (load_valid) begin
          if (r_wptr < DEPTH_W) begin
            w_we           = 1'b1;
            w_wptr_nxt     = r_wptr + 9'd1;
            w_prog_len_nxt = r_wptr + 9'd1;
          end else begin
            w_overflow_nxt = 1'b1;
          end
          if (load_last) w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (load_start) begin
          w_state_nxt    = S_LOAD;
          w_wptr_nxt     = '0;
          w_prog_len_nxt = '0;
          w_overflow_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, status and all outputs registered; outputs are precomputed from next state.
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_wptr        <= '0;
      r_prog_len    <= '0;
      r_overflow    <= 1'b0;
      r_load_ready  <= 1'b0;
      r_cpu_reset   <= 1'b1;
      r_running     <= 1'b0;
      r_instruction <= HOLD_INSN;
    end else begin
      r_state       <= w_state_nxt;
      r_wptr        <= w_wptr_nxt;
      r_prog_len    <= w_prog_len_nxt;
      r_overflow    <= w_overflow_nxt;
      r_load_ready  <= (w_state_nxt == S_LOAD) && (w_wptr_nxt < DEPTH_W);
      r_cpu_reset   <= (w_state_nxt != S_RUN);
      r_running     <= (w_state_nxt == S_RUN);
      // fetch only while staying in RUN, so leaving RUN shows HOLD_INSN at once
      r_instruction <= ((r_state == S_RUN) && (w_state_nxt == S_RUN) && w_fetch_hit)
                       ? r_mem[w_raddr] : HOLD_INSN;
    end
  end

  // Program storage; deliberately not cleared by reset.
  always_ff @(posedge clk50) begin
    if (w_we) r_mem[r_wptr[AW-1:0]] <= load_data;
  end

  assign instruction = r_instruction;
  assign cpu_reset   = r_cpu_reset;
  assign load_ready  = r_load_ready;
  assign running     = r_running;
  assign prog_len    = r_prog_len;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_imem_loader;

  logic       clk50 = 1'b0;
  logic       reset;
  logic [7:0] address;
  logic       load_start, load_valid, load_last;
  logic [7:0] load_data;

  logic [7:0] a_insn, b_insn;
  logic       a_cpu_rst, b_cpu_rst, a_rdy, b_rdy, a_run, b_run, a_ovf, b_ovf;
  logic [8:0] a_plen, b_plen;

  imem_loader dut_a (
    .clk50(clk50), .reset(reset), .address(address), .instruction(a_insn),
    .cpu_reset(a_cpu_rst), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(a_rdy),
    .running(a_run), .prog_len(a_plen), .overflow(a_ovf)
  );

  imem_loader #(.DEPTH(4)) dut_b (
    .clk50(clk50), .reset(reset), .address(address), .instruction(b_insn),
    .cpu_reset(b_cpu_rst), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(b_rdy),
    .running(b_run), .prog_len(b_plen), .overflow(b_ovf)
  );

  always #5 clk50 = ~clk50;

  // selector: 0 insn, 1 cpu_reset, 2 load_ready, 3 running, 4 prog_len, 5 overflow; +10 = dut_b
  typedef struct {
    string      name;
    int         sel;
    logic [8:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [8:0] probe(input int sel);
    case (sel)
      0:  return {1'b0, a_insn};
      1:  return {8'd0, a_cpu_rst};
      2:  return {8'd0, a_rdy};
      3:  return {8'd0, a_run};
      4:  return a_plen;
      5:  return {8'd0, a_ovf};
      10: return {1'b0, b_insn};
      11: return {8'd0, b_cpu_rst};
      12: return {8'd0, b_rdy};
      13: return {8'd0, b_run};
      14: return b_plen;
      15: return {8'd0, b_ovf};
      default: return 9'h1FF;
    endcase
  endfunction

  task automatic expect_v(input string name, input int sel, input logic [8:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    sbq.push_back(e);
  endtask

  // Monitor: compare every queued expectation at the falling edge.
  always @(negedge clk50) begin
    exp_t       e;
    logic [8:0] act;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      act = probe(e.sel);
      n_vec++;
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
  endtask

  task automatic idle_inputs();
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = 8'h00;
  endtask

  task automatic check_reset_vals(input string tag);
    expect_v({tag, "_insn"}, 0, 9'h0C3);
    expect_v({tag, "_cpurst"}, 1, 9'd1);
    expect_v({tag, "_rdy"}, 2, 9'd0);
    expect_v({tag, "_run"}, 3, 9'd0);
    expect_v({tag, "_plen"}, 4, 9'd0);
    expect_v({tag, "_ovf"}, 5, 9'd0);
  endtask

  logic [7:0] t3_bytes [4] = '{8'hA1, 8'hB2, 8'hD4, 8'hE5};

  initial begin
    idle_inputs();
    address = 8'd0;
    reset   = 1'b0;

    // 1: reset values
    repeat (3) tick();
    check_reset_vals("t1");
    expect_v("t1_b_rdy", 12, 9'd0);
    expect_v("t1_b_plen", 14, 9'd0);
    tick();
    reset = 1'b1;
    tick();

    // 2: load three bytes, run, fetch
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    expect_v("t2_rdy", 2, 9'd1);
    expect_v("t2_cpurst_load", 1, 9'd1);
    send(8'h05, 1'b0);
    send(8'h4C, 1'b0);
    send(8'h81, 1'b1);
    idle_inputs();
    expect_v("t2_plen", 4, 9'd3);
    expect_v("t2_run", 3, 9'd1);
    expect_v("t2_cpurst", 1, 9'd0);
    expect_v("t2_rdy_after", 2, 9'd0);
    expect_v("t2_first_run_insn", 0, 9'h0C3);
    address = 8'd1;
    tick();
    expect_v("t2_addr1", 0, 9'h04C);
    address = 8'd7;
    tick();
    expect_v("t2_addr7", 0, 9'h0C3);

    // 3: gappy valid, readback
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(t3_bytes[i], (i == 3));
      if (i != 3) begin
        load_valid = 1'b0;
        load_data  = 8'hFF;
        load_last  = 1'b0;
        tick();
      end
    end
    idle_inputs();
    expect_v("t3_plen", 4, 9'd4);
    expect_v("t3_run", 3, 9'd1);
    for (int i = 0; i < 4; i++) begin
      address = 8'(i);
      tick();
      expect_v($sformatf("t3_rd%0d", i), 0, {1'b0, t3_bytes[i]});
    end
    address = 8'd4;
    tick();
    expect_v("t3_rd4", 0, 9'h0C3);

    // 4: DEPTH=4 overflow (dut_b)
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    expect_v("t4_b_rdy0", 12, 9'd1);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    expect_v("t4_b_rdy3", 12, 9'd1);
    send(8'h44, 1'b0);
    expect_v("t4_b_rdy_full", 12, 9'd0);
    expect_v("t4_b_ovf_pre", 15, 9'd0);
    expect_v("t4_b_plen_full", 14, 9'd4);
    send(8'h55, 1'b0);
    expect_v("t4_b_ovf", 15, 9'd1);
    expect_v("t4_b_run_pre", 13, 9'd0);
    send(8'h66, 1'b1);
    idle_inputs();
    expect_v("t4_b_run", 13, 9'd1);
    expect_v("t4_b_plen", 14, 9'd4);
    expect_v("t4_b_ovf_hold", 15, 9'd1);
    expect_v("t4_b_cpurst", 11, 9'd0);
    expect_v("t4_a_plen", 4, 9'd6);
    address = 8'd3;
    tick();
    expect_v("t4_b_addr3", 10, 9'h044);
    address = 8'd4;
    tick();
    expect_v("t4_b_addr4", 10, 9'h0C3);
    expect_v("t4_a_addr4", 0, 9'h055);

    // 5: load_start while running (address 0 would otherwise hit)
    address = 8'd0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    expect_v("t5_run", 3, 9'd0);
    expect_v("t5_cpurst", 1, 9'd1);
    expect_v("t5_plen", 4, 9'd0);
    expect_v("t5_insn", 0, 9'h0C3);
    expect_v("t5_rdy", 2, 9'd1);

    // 6: async reset mid-load, then reload from address 0
    send(8'h77, 1'b0);
    send(8'h88, 1'b0);
    idle_inputs();
    expect_v("t6_plen_part", 4, 9'd2);
    tick();
    #1 reset = 1'b0;
    #1;
    check_reset_vals("t6_async");
    repeat (2) tick();
    reset = 1'b1;
    tick();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    send(8'h9A, 1'b0);
    send(8'hBC, 1'b1);
    idle_inputs();
    expect_v("t6_plen", 4, 9'd2);
    for (int i = 0; i < 3; i++) begin
      address = 8'(i);
      tick();
      case (i)
        0: expect_v("t6_rd0", 0, 9'h09A);
        1: expect_v("t6_rd1", 0, 9'h0BC);
        default: expect_v("t6_rd2", 0, 9'h0C3);
      endcase
    end

    tick();
    @(negedge clk50);
    #1;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
